// File: rtl/mas_mul_issue_collect.sv
// mas_mul_issue_collect
//
// Stream adapter wrapped around a fixed-latency WIDTH x WIDTH multiplier core.
// Operand pairs arrive on a valid/ready slave port and are registered onto
// the core inputs. A valid shift register follows each operation through the
// core latency, and the product is captured into an in-order, first-word
// fall-through result FIFO drained through a valid/ready master port.
//
// Flow control is credit based. One credit exists per FIFO entry. A credit
// is held from the accept edge until the pop edge, so every accepted
// operation is guaranteed a FIFO slot when its product emerges from the core.
//
// Ports
//   clk      in   1        clock, all state updates on the rising edge
//   rst      in   1        synchronous active-high reset
//   s_valid  in   1        operand pair valid
//   s_ready  out  1        block can accept an operand pair
//   s_in1    in   WIDTH    operand A
//   s_in2    in   WIDTH    operand B
//   mul_in1  out  WIDTH    registered operand A to the core
//   mul_in2  out  WIDTH    registered operand B to the core
//   mul_res  in   2*WIDTH  product from the core
//   m_valid  out  1        result available at the FIFO head
//   m_ready  in   1        consumer takes the head result
//   m_res    out  2*WIDTH  head result
//   busy     out  1        operation in flight or FIFO non-empty
//   ovf_err  out  1        sticky: capture attempted while the FIFO was full

module mas_mul_issue_collect #(
  parameter int WIDTH      = 32,
  parameter int MUL_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WIDTH-1:0]     s_in1,
  input  logic [WIDTH-1:0]     s_in2,
  output logic [WIDTH-1:0]     mul_in1,
  output logic [WIDTH-1:0]     mul_in2,
  input  logic [2*WIDTH-1:0]   mul_res,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [2*WIDTH-1:0]   m_res,
  output logic                 busy,
  output logic                 ovf_err
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_EXT = (CW + 1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR  = PW'(FIFO_DEPTH - 1);

  // Pointer advance with wrap at FIFO_DEPTH (depth need not be a power of 2).
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  logic [MUL_LAT:0]     vld_sr;
  logic [CW-1:0]        fifo_count;
  logic [CW-1:0]        inflight;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [2*WIDTH-1:0]   mem [FIFO_DEPTH];

  logic                 accept;
  logic                 capture;
  logic                 pop;
  logic                 full;
  logic                 wr_en;
  logic [CW:0]          used;

  assign accept  = s_valid && s_ready;
  assign capture = vld_sr[MUL_LAT];
  assign pop     = m_valid && m_ready;
  assign full    = (fifo_count == DEPTH_C);
  // A full FIFO can still take a capture when the head leaves on the same edge.
  assign wr_en   = capture && (!full || pop);

  // Credits are decoded purely from registered counts: no path from m_ready
  // or s_valid reaches s_ready.
  assign used    = {1'b0, fifo_count} + {1'b0, inflight};
  assign s_ready = (used < DEPTH_EXT);

  assign m_valid = (fifo_count != '0);
  assign m_res   = mem[rd_ptr];
  assign busy    = (inflight != '0) || (fifo_count != '0);

  // Issue stage: operands registered onto the core inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_in1 <= '0;
      mul_in2 <= '0;
    end else if (accept) begin
      mul_in1 <= s_in1;
      mul_in2 <= s_in2;
    end
  end

  // Tracking stage: bit i is set during the i-th cycle after the accept
  // edge, so bit MUL_LAT marks the cycle in which mul_res holds the product.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr <= '0;
    end else begin
      vld_sr <= {vld_sr[MUL_LAT-1:0], accept};
    end
  end

  // In-flight count: operations issued but not yet captured. A dropped
  // capture still leaves the core, so it still decrements.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({accept, capture})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Collect stage: result FIFO control.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      ovf_err    <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (capture && !wr_en) begin
        ovf_err <= 1'b1;
      end
    end
  end

  // Result storage. Cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= mul_res;
    end
  end

endmodule

// File: tb/tb_mas_mul_issue_collect.sv
module tb_mas_mul_issue_collect;

  localparam int WIDTH      = 32;
  localparam int MUL_LAT    = 2;
  localparam int FIFO_DEPTH = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                s_valid;
  logic                s_ready;
  logic [WIDTH-1:0]    s_in1;
  logic [WIDTH-1:0]    s_in2;
  logic [WIDTH-1:0]    mul_in1;
  logic [WIDTH-1:0]    mul_in2;
  logic [2*WIDTH-1:0]  mul_res;
  logic                m_valid;
  logic                m_ready;
  logic [2*WIDTH-1:0]  m_res;
  logic                busy;
  logic                ovf_err;

  mas_mul_issue_collect #(
    .WIDTH(WIDTH), .MUL_LAT(MUL_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_in1(s_in1), .s_in2(s_in2),
    .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_res(mul_res),
    .m_valid(m_valid), .m_ready(m_ready), .m_res(m_res),
    .busy(busy), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  // Two-stage multiplier core model, never reset (stale products keep flowing).
  logic [63:0] mres_p1, mres_p2;
  always @(posedge clk) begin
    mres_p1 <= {32'b0, mul_in1} * {32'b0, mul_in2};
    mres_p2 <= mres_p1;
  end
  assign mul_res = mres_p2;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Streaming scoreboard
  logic [63:0] exp_q[$];
  int   n_acc = 0;
  int   n_pop = 0;
  logic acc_now;
  logic last_s_ready;

  // One clock: sample at negedge, then return 1 time unit after the next posedge.
  task automatic step();
    @(negedge clk);
    last_s_ready = s_ready;
    acc_now      = s_valid && s_ready;
    if (acc_now) begin
      exp_q.push_back({32'b0, s_in1} * {32'b0, s_in2});
      n_acc++;
    end
    if (m_valid && m_ready) begin
      n_pop++;
      if (exp_q.size() == 0) chk("pop_unexpected", m_res, 64'hX);
      else chk("pop_data", m_res, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  // Single operation from idle; measures latency in negedges after accept edge.
  task automatic run_single(input logic [31:0] a, input logic [31:0] b, input logic [63:0] p);
    int first;
    int nv;
    first = 0;
    nv    = 0;
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_in1   = a;
    s_in2   = b;
    @(negedge clk);
    chk("single_s_ready", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) chk("single_busy", 64'(busy), 64'd1);
      if (m_valid) begin
        nv++;
        if (first == 0) begin
          first = c;
          chk("single_data", m_res, p);
        end
      end
    end
    chk("single_latency", 64'(first), 64'd4);
    chk("single_vcount", 64'(nv), 64'd1);
    chk("single_idle", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t vt[7];
  logic [31:0] ra[100];
  logic [31:0] rb[100];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int p0;
    int c0;
    int cyc;
    int sent;

    vt[0] = '{32'd3,          32'd5,          64'd15};
    vt[1] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE00000001};
    vt[2] = '{32'd0,          32'hFFFFFFFF,   64'd0};
    vt[3] = '{32'd7,          32'd9,          64'd63};
    vt[4] = '{32'h80000000,   32'd2,          64'h100000000};
    vt[5] = '{32'hFFFFFFFF,   32'd2,          64'h1FFFFFFFE};
    vt[6] = '{32'h12345678,   32'h10,         64'h123456780};

    rst = 1'b1; s_valid = 1'b0; s_in1 = '0; s_in2 = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_busy",    64'(busy),    64'd0);
    chk("rst_m_res",   m_res,        64'd0);
    chk("rst_ovf",     64'(ovf_err), 64'd0);
    chk("rst_mul_in1", 64'(mul_in1), 64'd0);
    @(posedge clk);
    #1;

    // Table-driven single operations
    for (int i = 0; i < 7; i++) run_single(vt[i].a, vt[i].b, vt[i].p);

    // Backpressure: operands k*2, k=1..6, consumer stalled
    m_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      s_valid = (idx < 6);
      s_in1 = 32'(idx + 1);
      s_in2 = 32'd2;
      step();
      if (acc_now) idx++;
    end
    chk("bp_accepts", 64'(idx), 64'd4);
    chk("bp_s_ready", 64'(last_s_ready), 64'd0);
    chk("bp_ovf", 64'(ovf_err), 64'd0);
    m_ready = 1'b1;
    p0 = n_pop;
    for (int c = 0; c < 40 && (n_pop - p0) < 6; c++) begin
      s_valid = (idx < 6);
      s_in1 = 32'(idx + 1);
      s_in2 = 32'd2;
      step();
      if (acc_now) idx++;
    end
    s_valid = 1'b0;
    chk("bp_pops", 64'(n_pop - p0), 64'd6);
    chk("bp_ovf_end", 64'(ovf_err), 64'd0);

    // Throughput: 100 random pairs with the consumer always ready
    for (int i = 0; i < 100; i++) begin
      ra[i] = $urandom;
      rb[i] = $urandom;
    end
    ra[0] = 32'hFFFFFFFF; rb[0] = 32'hFFFFFFFF;
    sent = 0;
    cyc  = 0;
    p0   = n_pop;
    m_ready = 1'b1;
    while (cyc < 400 && (n_pop - p0) < 100) begin
      s_valid = (sent < 100);
      s_in1 = (sent < 100) ? ra[sent] : 32'd0;
      s_in2 = (sent < 100) ? rb[sent] : 32'd0;
      step();
      if (acc_now) sent++;
      cyc++;
    end
    s_valid = 1'b0;
    chk("tp_pops", 64'(n_pop - p0), 64'd100);
    chk("tp_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("tp_rate", 64'(cyc <= 140), 64'd1);
    chk("tp_ovf", 64'(ovf_err), 64'd0);

    // Full boundary: fill with the consumer stalled, then pop one at a time
    m_ready = 1'b0;
    idx = 20;
    for (int c = 0; c < 10; c++) begin
      s_valid = 1'b1;
      s_in1 = 32'(idx);
      s_in2 = 32'd3;
      step();
      if (acc_now) idx++;
    end
    chk("full_accepts", 64'(idx - 20), 64'd4);
    chk("full_s_ready", 64'(last_s_ready), 64'd0);
    chk("full_m_valid", 64'(m_valid), 64'd1);
    m_ready = 1'b1; s_in1 = 32'(idx); step(); if (acc_now) idx++;
    chk("full_pop1_blocked", 64'(last_s_ready), 64'd0);
    m_ready = 1'b0; s_in1 = 32'(idx); step(); if (acc_now) idx++;
    chk("full_after_pop1", 64'(last_s_ready), 64'd1);
    m_ready = 1'b1; s_in1 = 32'(idx); step(); if (acc_now) idx++;
    chk("full_reconsumed", 64'(last_s_ready), 64'd0);
    m_ready = 1'b0; s_in1 = 32'(idx); step(); if (acc_now) idx++;
    chk("full_after_pop2", 64'(last_s_ready), 64'd1);
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (20) step();
    chk("full_drained", 64'(exp_q.size()), 64'd0);
    chk("full_m_valid_end", 64'(m_valid), 64'd0);
    chk("full_ovf", 64'(ovf_err), 64'd0);

    // Reset with three operations in flight
    c0 = n_acc;
    for (int c = 0; c < 3; c++) begin
      s_valid = 1'b1;
      s_in1 = 32'(c + 2);
      s_in2 = 32'd11;
      step();
    end
    s_valid = 1'b0;
    chk("mid_accepts", 64'(n_acc - c0), 64'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mid_m_valid", 64'(m_valid), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_s_ready", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;
    p0 = n_pop;
    repeat (8) step();
    chk("mid_no_stale", 64'(n_pop - p0), 64'd0);
    run_single(32'd7, 32'd9, 64'd63);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
